// File: rtl/aes_pkg.sv
// Shared definitions for the iterative AES-128 encryption controller.
//   aes_state_t    : 128-bit AES state, byte k at [8k+7:8k] (byte 0 = first FIPS-197 byte)
//   aes_ctrl_st_e  : controller FSM states
//   AES_NR, AES_RK_IDX_W : round count and round-key index width
//   aes_get_byte / aes_set_byte : byte-index helpers over aes_state_t
//   aes_sbox / aes_xtime        : byte-level primitives used by the round datapath
package aes_pkg;

    localparam int AES_NR       = 10;
    localparam int AES_RK_IDX_W = 4;

    typedef logic [127:0] aes_state_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROUND,
        ST_FINAL,
        ST_DONE
    } aes_ctrl_st_e;

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] AES_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] aes_get_byte(input aes_state_t s, input int k);
        return s[8*k +: 8];
    endfunction

    function automatic aes_state_t aes_set_byte(input aes_state_t s, input int k,
                                                input logic [7:0] b);
        aes_state_t r;
        r = s;
        r[8*k +: 8] = b;
        return r;
    endfunction

    // Entry b sits at bit offset (255-b)*8, and 255-b is ~b for an 8-bit index.
    function automatic logic [7:0] aes_sbox(input logic [7:0] b);
        logic [10:0] idx;
        idx = {~b, 3'b000};
        return AES_SBOX[idx +: 8];
    endfunction

    function automatic logic [7:0] aes_xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_round_dp.sv
// Combinational AES round: SubBytes -> ShiftRows -> MixColumns -> AddRoundKey.
// MixColumns is bypassed when 'last' is high (final round).
// Ports:
//   state      in  128 : current state
//   rk         in  128 : round key
//   last       in  1   : final-round select
//   next_state out 128 : round result
module aes_round_dp
    import aes_pkg::*;
(
    input  logic [127:0] state,
    input  logic [127:0] rk,
    input  logic         last,
    output logic [127:0] next_state
);

    aes_state_t sr;
    aes_state_t mc;
    logic [7:0] a0, a1, a2, a3;

    always_comb begin
        sr = '0;
        mc = '0;
        a0 = '0;
        a1 = '0;
        a2 = '0;
        a3 = '0;
        // Combined SubBytes/ShiftRows: row r of column c takes the byte from column (c+r) mod 4.
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr = aes_set_byte(sr, r + 4*c,
                                  aes_sbox(aes_get_byte(state, r + 4*((c + r) % 4))));
            end
        end
        for (int c = 0; c < 4; c++) begin
            a0 = aes_get_byte(sr, 4*c + 0);
            a1 = aes_get_byte(sr, 4*c + 1);
            a2 = aes_get_byte(sr, 4*c + 2);
            a3 = aes_get_byte(sr, 4*c + 3);
            mc = aes_set_byte(mc, 4*c + 0, aes_xtime(a0) ^ aes_xtime(a1) ^ a1 ^ a2 ^ a3);
            mc = aes_set_byte(mc, 4*c + 1, a0 ^ aes_xtime(a1) ^ aes_xtime(a2) ^ a2 ^ a3);
            mc = aes_set_byte(mc, 4*c + 2, a0 ^ a1 ^ aes_xtime(a2) ^ aes_xtime(a3) ^ a3);
            mc = aes_set_byte(mc, 4*c + 3, aes_xtime(a0) ^ a0 ^ a1 ^ a2 ^ aes_xtime(a3));
        end
        next_state = (last ? sr : mc) ^ rk;
    end

endmodule

// File: rtl/aes_enc_iter_ctrl.sv
// Iterative AES-128 encryption controller: one round per clock over a shared
// 128-bit state register, round keys fetched by index from an external store.
// Ports:
//   clk, rst               : clock (rising edge), synchronous active-high reset
//   in_valid/in_ready      : plaintext handshake, in_data 128-bit plaintext
//   rk_idx / rk_data       : round-key index out, round key in (same cycle)
//   out_valid/out_ready    : ciphertext handshake, out_data 128-bit ciphertext
//   busy                   : high whenever the FSM is not IDLE
// Optional: define AES_ROUND_TRACE_EN to add trace_valid / trace_state, which
// pulse once per state-register update with the updated state.
module aes_enc_iter_ctrl
    import aes_pkg::*;
#(
    parameter int NR       = AES_NR,
    parameter int RK_IDX_W = AES_RK_IDX_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [127:0]        in_data,
    output logic [RK_IDX_W-1:0] rk_idx,
    input  logic [127:0]        rk_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        out_data,
    output logic                busy
`ifdef AES_ROUND_TRACE_EN
    ,
    output logic                trace_valid,
    output logic [127:0]        trace_state
`endif
);

    localparam logic [3:0] RND_LAST   = 4'(NR);
    localparam logic [3:0] RND_PENULT = 4'(NR - 1);

    aes_ctrl_st_e st_q, st_d;
    logic [3:0]   rnd_q, rnd_d;
    aes_state_t   state_q, state_d;

    logic         upd;
    aes_state_t   upd_val;
    logic [3:0]   rk_sel;
    logic         dp_last;
    aes_state_t   dp_next;

    assign dp_last = (st_q == ST_FINAL);

    aes_round_dp u_round_dp (
        .state      (state_q),
        .rk         (rk_data),
        .last       (dp_last),
        .next_state (dp_next)
    );

    always_comb begin
        st_d      = st_q;
        rnd_d     = rnd_q;
        upd       = 1'b0;
        upd_val   = state_q;
        rk_sel    = 4'd0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        case (st_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                rnd_d    = 4'd0;
                if (in_valid) begin
                    upd     = 1'b1;
                    upd_val = in_data ^ rk_data;
                    rnd_d   = 4'd1;
                    st_d    = ST_ROUND;
                end
            end
            ST_ROUND: begin
                // Any counter value outside the round range is treated as corruption.
                if (rnd_q >= 4'd1 && rnd_q <= RND_PENULT) begin
                    rk_sel  = rnd_q;
                    upd     = 1'b1;
                    upd_val = dp_next;
                    rnd_d   = rnd_q + 4'd1;
                    if (rnd_q == RND_PENULT) begin
                        st_d = ST_FINAL;
                    end
                end else begin
                    st_d  = ST_IDLE;
                    rnd_d = 4'd0;
                end
            end
            ST_FINAL: begin
                if (rnd_q == RND_LAST) begin
                    rk_sel  = rnd_q;
                    upd     = 1'b1;
                    upd_val = dp_next;
                    st_d    = ST_DONE;
                end else begin
                    st_d  = ST_IDLE;
                    rnd_d = 4'd0;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                out_data  = state_q;
                if (out_ready) begin
                    st_d  = ST_IDLE;
                    rnd_d = 4'd0;
                end
            end
            default: begin
                st_d  = ST_IDLE;
                rnd_d = 4'd0;
            end
        endcase
        state_d = upd ? upd_val : state_q;
    end

    assign rk_idx = RK_IDX_W'(rk_sel);
    assign busy   = (st_q != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q    <= ST_IDLE;
            rnd_q   <= 4'd0;
            state_q <= '0;
        end else begin
            st_q    <= st_d;
            rnd_q   <= rnd_d;
            state_q <= state_d;
        end
    end

`ifdef AES_ROUND_TRACE_EN
    logic       trace_valid_q, trace_valid_d;
    aes_state_t trace_state_q, trace_state_d;

    assign trace_valid_d = upd;
    assign trace_state_d = upd ? upd_val : trace_state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            trace_valid_q <= 1'b0;
            trace_state_q <= '0;
        end else begin
            trace_valid_q <= trace_valid_d;
            trace_state_q <= trace_state_d;
        end
    end

    assign trace_valid = trace_valid_q;
    assign trace_state = trace_state_q;
`endif

endmodule
